// File: rtl/read_reorder_buffer.sv
// Reorder buffer between the decoder's tagged read port and memory: allocates a slot per
// request, accepts responses in any order and pushes them back strictly in request order.
module read_reorder_buffer #(
  parameter int ADDR_WIDTH = 48,
  parameter int DATA_WIDTH = 64,
  parameter int TAG_COUNT  = 4,
  parameter int TAG_WIDTH  = $clog2(TAG_COUNT),
  parameter int DEPTH      = 16,
  parameter int ID_WIDTH   = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  req_stall,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [ID_WIDTH-1:0]   mem_req_id,
  input  logic                  mem_req_stall,
  input  logic                  mem_rsp,
  input  logic [ID_WIDTH-1:0]   mem_rsp_id,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  output logic                  push,
  output logic [TAG_WIDTH-1:0]  push_tag,
  output logic [DATA_WIDTH-1:0] data,
  output logic [ID_WIDTH:0]     outstanding,
  output logic                  err
);

  localparam logic [ID_WIDTH:0] FullCount = DEPTH[ID_WIDTH:0];

  logic [ID_WIDTH-1:0]   head_q, head_d, tail_q, tail_d;
  logic [ID_WIDTH:0]     count_q, count_d;
  logic [DEPTH-1:0]      valid_q, valid_d, alloc_q, alloc_d;
  logic [TAG_WIDTH-1:0]  tag_q [DEPTH];
  logic [DATA_WIDTH-1:0] ram_q [DEPTH];
  logic                  push_q, err_q;
  logic [TAG_WIDTH-1:0]  pushTag_q;
  logic [DATA_WIDTH-1:0] data_q;

  logic accept, rspOk, rspBad, bypass, retire;
  logic [DATA_WIDTH-1:0] retireData;

  // Stall depends only on registered occupancy and memory stall, never on req.
  assign req_stall    = mem_req_stall || (count_q == FullCount);
  assign mem_req      = req && !req_stall;
  assign mem_req_id   = tail_q;
  assign mem_req_addr = req_addr;
  assign accept       = mem_req;

  // A response for the current head slot is retired immediately instead of stored.
  assign rspOk      = mem_rsp && alloc_q[mem_rsp_id] && !valid_q[mem_rsp_id];
  assign rspBad     = mem_rsp && !rspOk;
  assign bypass     = rspOk && (mem_rsp_id == head_q);
  assign retire     = valid_q[head_q] || bypass;
  assign retireData = valid_q[head_q] ? ram_q[head_q] : mem_rsp_data;

  always_comb begin
    valid_d = valid_q;
    alloc_d = alloc_q;
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (rspOk && !bypass) valid_d[mem_rsp_id] = 1'b1;
    if (retire) begin
      valid_d[head_q] = 1'b0;
      alloc_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    if (accept) begin
      alloc_d[tail_q] = 1'b1;
      valid_d[tail_q] = 1'b0;
      tail_d          = tail_q + 1'b1;
    end
    if (accept && !retire)      count_d = count_q + 1'b1;
    else if (!accept && retire) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      valid_q   <= '0;
      alloc_q   <= '0;
      push_q    <= 1'b0;
      pushTag_q <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      alloc_q <= alloc_d;
      push_q  <= retire;
      if (retire) begin
        pushTag_q <= tag_q[head_q];
        data_q    <= retireData;
      end
      if (rspBad) err_q <= 1'b1;
    end
  end

  // Slot payload storage; occupancy bits alone decide whether an entry is meaningful.
  always_ff @(posedge clk) begin
    if (!rst && accept) tag_q[tail_q] <= req_tag;
    if (!rst && rspOk && !bypass) ram_q[mem_rsp_id] <= mem_rsp_data;
  end

  assign push        = push_q;
  assign push_tag    = pushTag_q;
  assign data        = data_q;
  assign outstanding = count_q;
  assign err         = err_q;

endmodule

// File: tb/tb_read_reorder_buffer.sv
// Directed bench for read_reorder_buffer: an in-order queue model checked every cycle,
// plus hand-computed literal expectations along the directed scenarios.
module tb_read_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [1:0]  req_tag;
  logic [47:0] req_addr;
  logic        req_stall;
  logic        mem_req;
  logic [47:0] mem_req_addr;
  logic [3:0]  mem_req_id;
  logic        mem_req_stall;
  logic        mem_rsp;
  logic [3:0]  mem_rsp_id;
  logic [63:0] mem_rsp_data;
  logic        push;
  logic [1:0]  push_tag;
  logic [63:0] data;
  logic [4:0]  outstanding;
  logic        err;

  int checks = 0;
  int errors = 0;

  read_reorder_buffer dut (
    .clk(clk), .rst(rst), .req(req), .req_tag(req_tag), .req_addr(req_addr),
    .req_stall(req_stall), .mem_req(mem_req), .mem_req_addr(mem_req_addr),
    .mem_req_id(mem_req_id), .mem_req_stall(mem_req_stall), .mem_rsp(mem_rsp),
    .mem_rsp_id(mem_rsp_id), .mem_rsp_data(mem_rsp_data), .push(push),
    .push_tag(push_tag), .data(data), .outstanding(outstanding), .err(err)
  );

  always #5 clk = ~clk;

  // Model: ordered list of outstanding requests, each waiting for its data.
  typedef struct {
    logic [1:0]  tag;
    logic [3:0]  id;
    logic        has;
    logic [63:0] d;
  } entT;

  entT         q[$];
  int          tailId = 0;
  bit          modelValid = 0;
  logic        expPush = 0, expErr = 0;
  logic [1:0]  expTag = 0;
  logic [63:0] expData = 0;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      tailId  = 0;
      expPush = 0;
      expTag  = 0;
      expData = 0;
      expErr  = 0;
    end else begin
      bit stall;
      int found;
      stall = mem_req_stall || (q.size() == 16);
      if (mem_rsp) begin
        found = -1;
        foreach (q[i]) if (q[i].id == mem_rsp_id) found = i;
        if (found < 0 || q[found].has) expErr = 1;
        else begin
          q[found].has = 1;
          q[found].d   = mem_rsp_data;
        end
      end
      expPush = 0;
      if (q.size() > 0 && q[0].has) begin
        expPush = 1;
        expTag  = q[0].tag;
        expData = q[0].d;
        void'(q.pop_front());
      end
      if (req && !stall) begin
        q.push_back('{tag: req_tag, id: tailId[3:0], has: 1'b0, d: 64'h0});
        tailId = (tailId + 1) % 16;
      end
    end
    modelValid = 1;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of registered and combinational outputs against the model.
  always @(negedge clk) begin
    if (modelValid) begin
      logic expStall;
      expStall = mem_req_stall || (q.size() == 16);
      checkOutput("push", 64'(push), 64'(expPush));
      if (expPush) begin
        checkOutput("push_tag", 64'(push_tag), 64'(expTag));
        checkOutput("data", data, expData);
      end
      checkOutput("outstanding", 64'(outstanding), 64'(q.size()));
      checkOutput("err", 64'(err), 64'(expErr));
      checkOutput("req_stall", 64'(req_stall), 64'(expStall));
      checkOutput("mem_req", 64'(mem_req), 64'(req && !expStall));
      if (req && !expStall) begin
        checkOutput("mem_req_id", 64'(mem_req_id), 64'(tailId));
        checkOutput("mem_req_addr", 64'(mem_req_addr), 64'(req_addr));
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic [1:0] t, input logic [47:0] a,
                               input logic rs, input logic [3:0] id, input logic [63:0] d,
                               input logic ms);
    @(posedge clk);
    #1;
    rst           = 1'b0;
    req           = r;
    req_tag       = t;
    req_addr      = a;
    mem_rsp       = rs;
    mem_rsp_id    = id;
    mem_rsp_data  = d;
    mem_req_stall = ms;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic doReq(input logic [1:0] t, input logic [47:0] a);
    applyStimulus(1, t, a, 0, 0, 0, 0);
  endtask

  task automatic doRsp(input logic [3:0] id, input logic [63:0] d);
    applyStimulus(0, 0, 0, 1, id, d, 0);
  endtask

  task automatic pulseReset();
    @(posedge clk);
    #1;
    rst     = 1'b1;
    req     = 1'b0;
    mem_rsp = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 0; req_tag = 0; req_addr = 0;
    mem_req_stall = 0; mem_rsp = 0; mem_rsp_id = 0; mem_rsp_data = 0;
    idle();
    @(negedge clk);
    checkOutput("lit_reset_push", 64'(push), 0);
    checkOutput("lit_reset_err", 64'(err), 0);
    checkOutput("lit_reset_outstanding", 64'(outstanding), 0);
    checkOutput("lit_reset_stall", 64'(req_stall), 0);

    // In-order single request, first offered while memory stalls.
    applyStimulus(1, 1, 48'h1000, 0, 0, 0, 1);
    @(negedge clk);
    checkOutput("lit_stalled_memreq", 64'(mem_req), 0);
    checkOutput("lit_stalled_reqstall", 64'(req_stall), 1);
    doReq(1, 48'h1000);
    @(negedge clk);
    checkOutput("lit_memreq", 64'(mem_req), 1);
    checkOutput("lit_memreq_id", 64'(mem_req_id), 0);
    checkOutput("lit_memreq_addr", 64'(mem_req_addr), 64'h1000);
    idle();
    @(negedge clk);
    checkOutput("lit_outstanding1", 64'(outstanding), 1);
    idle();
    doRsp(0, 64'hAA);
    idle();
    @(negedge clk);
    checkOutput("lit_inorder_push", 64'(push), 1);
    checkOutput("lit_inorder_tag", 64'(push_tag), 1);
    checkOutput("lit_inorder_data", data, 64'hAA);
    checkOutput("lit_inorder_outstanding", 64'(outstanding), 0);

    // Out-of-order pair: slots 1 and 2, younger answered first.
    doReq(0, 48'h2000);
    doReq(2, 48'h2008);
    idle();
    doRsp(2, 64'hB);
    idle();
    @(negedge clk);
    checkOutput("lit_ooo_hold", 64'(push), 0);
    doRsp(1, 64'hA);
    idle();
    @(negedge clk);
    checkOutput("lit_ooo_first_tag", 64'(push_tag), 0);
    checkOutput("lit_ooo_first_data", data, 64'hA);
    idle();
    @(negedge clk);
    checkOutput("lit_ooo_second_tag", 64'(push_tag), 2);
    checkOutput("lit_ooo_second_data", data, 64'hB);

    // Full: 16 requests from slot 3 with no responses.
    for (int i = 0; i < 16; i++) doReq(2'(i % 4), 48'h3000 + 48'(i * 8));
    idle();
    @(negedge clk);
    checkOutput("lit_full_outstanding", 64'(outstanding), 16);
    checkOutput("lit_full_stall", 64'(req_stall), 1);
    doReq(3, 48'h4000);
    @(negedge clk);
    checkOutput("lit_full_no_memreq", 64'(mem_req), 0);
    doRsp(3, 64'h300);
    idle();
    @(negedge clk);
    checkOutput("lit_full_retire_push", 64'(push), 1);
    checkOutput("lit_full_retire_tag", 64'(push_tag), 0);
    checkOutput("lit_full_after_outstanding", 64'(outstanding), 15);
    checkOutput("lit_full_after_stall", 64'(req_stall), 0);
    for (int k = 1; k < 16; k++) doRsp(4'((3 + k) % 16), 64'(16'h300 + k));
    idle();
    idle();

    // Wrap-around: 10 groups of 4, each group answered in reverse.
    for (int g = 0; g < 10; g++) begin
      for (int k = 0; k < 4; k++) doReq(2'((g + k) % 4), 48'h8000 + 48'(g * 32 + k * 8));
      for (int k = 3; k >= 0; k--) doRsp(4'((3 + g * 4 + k) % 16), 64'(1000 + g * 16 + k));
    end
    repeat (5) idle();
    @(negedge clk);
    checkOutput("lit_wrap_err", 64'(err), 0);
    checkOutput("lit_wrap_outstanding", 64'(outstanding), 0);

    // Simultaneous accept and retire at count 8 (slots 11..2, new one gets slot 3).
    for (int i = 0; i < 8; i++) doReq(2'(i % 4), 48'h9000 + 48'(i * 8));
    idle();
    @(negedge clk);
    checkOutput("lit_simul_before", 64'(outstanding), 8);
    applyStimulus(1, 3, 48'h9100, 1, 11, 64'h5555, 0);
    idle();
    @(negedge clk);
    checkOutput("lit_simul_count", 64'(outstanding), 8);
    checkOutput("lit_simul_push", 64'(push), 1);
    checkOutput("lit_simul_data", data, 64'h5555);
    for (int k = 1; k <= 8; k++) doRsp(4'((11 + k) % 16), 64'(16'h6000 + k));
    idle();
    idle();

    // Error cases, then mid-operation reset.
    doRsp(5, 64'hDEAD);
    idle();
    @(negedge clk);
    checkOutput("lit_err_unalloc", 64'(err), 1);
    checkOutput("lit_err_no_push", 64'(push), 0);
    doReq(1, 48'hA000);
    doReq(2, 48'hA008);
    doRsp(5, 64'h77);
    doRsp(5, 64'h88);
    idle();
    @(negedge clk);
    checkOutput("lit_err_dup", 64'(err), 1);
    doRsp(4, 64'h66);
    idle();
    @(negedge clk);
    checkOutput("lit_dup_first_data", data, 64'h66);
    idle();
    @(negedge clk);
    checkOutput("lit_dup_kept_data", data, 64'h77);
    doReq(3, 48'hB000);
    pulseReset();
    idle();
    @(negedge clk);
    checkOutput("lit_rst_err", 64'(err), 0);
    checkOutput("lit_rst_outstanding", 64'(outstanding), 0);
    checkOutput("lit_rst_push", 64'(push), 0);
    doRsp(6, 64'h99);
    idle();
    @(negedge clk);
    checkOutput("lit_stale_rsp_err", 64'(err), 1);
    checkOutput("lit_stale_rsp_push", 64'(push), 0);
    idle();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
